// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle add/sub/logic/shift/pass-through ops and a
// multi-cycle unsigned shift-add multiplier. All results are registered and
// announced by a one-cycle done pulse.
module seq_alu #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             m,
  input  logic [3:0]       s,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] t,
  output logic [WIDTH-1:0] th,
  output logic             cf,
  output logic             zf,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic {IDLE, MUL} state_t;

  state_t              state;
  state_t              state_next;
  logic [CW-1:0]       cnt;
  logic [WIDTH-1:0]    op_a;
  logic [2*WIDTH-1:0]  prod;
  logic [2*WIDTH-1:0]  prod_next;
  logic [WIDTH:0]      upper_sum;
  logic                is_mul;
  logic                last_iter;

  // single-cycle result, computed straight from the inputs at the accepting edge
  logic [WIDTH-1:0]    r_t;
  logic                r_cf;
  logic                r_zf;
  logic                r_keep;
  logic [WIDTH:0]      sum;

  assign is_mul    = m && (s == 4'b0011);
  assign last_iter = (state == MUL) && (cnt == CW'(WIDTH - 1));
  assign busy      = (state == MUL);

  // Saturating nothing here: arithmetic wraps in t, the extra bit is the carry.
  function automatic logic [WIDTH:0] add3(input logic [WIDTH-1:0] x,
                                          input logic [WIDTH-1:0] y,
                                          input logic             ci);
    return {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, ci};
  endfunction

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // FSM next-state: enter MUL on an accepted multiply, leave after the last iteration
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start && is_mul) state_next = MUL;
      MUL:  if (last_iter)       state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // One shift-add step: add the multiplicand into the upper half when the
  // current multiplier bit is set, then shift the whole product right.
  always_comb begin
    upper_sum = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, op_a} : '0);
    prod_next = {upper_sum, prod[WIDTH-1:1]};
  end

  // Single-cycle op decode; r_keep marks pass-through ops that leave cf/zf alone
  always_comb begin
    r_t    = '0;
    r_cf   = 1'b0;
    r_zf   = 1'b0;
    r_keep = 1'b0;
    sum    = '0;
    if (m) begin
      case (s)
        4'b1001: begin sum = add3(a, b, 1'b0); r_t = sum[WIDTH-1:0]; r_cf = sum[WIDTH]; end
        4'b1000: begin sum = add3(a, b, cf);   r_t = sum[WIDTH-1:0]; r_cf = sum[WIDTH]; end
        4'b0110: begin sum = {1'b0, b} - {1'b0, a}; r_t = sum[WIDTH-1:0]; r_cf = sum[WIDTH]; end
        4'b1011: r_t = a & b;
        4'b0101: r_t = ~b;
        4'b1110: begin r_t = {b[WIDTH-2:0], 1'b0}; r_cf = b[WIDTH-1]; end
        4'b1101: begin r_t = {1'b0, b[WIDTH-1:1]}; r_cf = b[0]; end
        default: ;
      endcase
      case (s)
        4'b1001, 4'b1000, 4'b0110, 4'b1011,
        4'b0101, 4'b1110, 4'b1101: r_zf = (r_t == '0);
        default: r_zf = 1'b0;
      endcase
    end else begin
      case (s)
        4'b1010:          begin r_t = b; r_keep = 1'b1; end
        4'b1100, 4'b0100: begin r_t = a; r_keep = 1'b1; end
        default: ;
      endcase
    end
  end

  // Datapath and result registers; a reset mid-multiply discards the op silently
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t    <= '0;
      th   <= '0;
      cf   <= 1'b0;
      zf   <= 1'b0;
      done <= 1'b0;
      cnt  <= '0;
      op_a <= '0;
      prod <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (is_mul) begin
              op_a <= a;
              prod <= {{WIDTH{1'b0}}, b};
              cnt  <= '0;
            end else begin
              t    <= r_t;
              th   <= '0;
              done <= 1'b1;
              if (!r_keep) begin
                cf <= r_cf;
                zf <= r_zf;
              end
            end
          end
        end
        MUL: begin
          prod <= prod_next;
          cnt  <= cnt + 1'b1;
          if (last_iter) begin
            t    <= prod_next[WIDTH-1:0];
            th   <= prod_next[2*WIDTH-1:WIDTH];
            cf   <= |prod_next[2*WIDTH-1:WIDTH];
            zf   <= (prod_next == '0);
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu: one 8-bit and one 16-bit instance, directed vector
// tables, hand sequences for multi-cycle/reset corners, and random ops
// checked against an arithmetic reference model.
module tb_seq_alu;

  typedef struct packed {
    logic [63:0] t;
    logic [63:0] th;
    logic        cf;
    logic        zf;
  } res_t;

  typedef struct packed {
    logic        m;
    logic [3:0]  s;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] t;
    logic [63:0] th;
    logic        cf;
    logic        zf;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        m;
  logic [3:0]  s;
  logic        start8, start16;
  logic [7:0]  a8, b8, t8, th8;
  logic [15:0] a16, b16, t16, th16;
  logic        cf8, zf8, busy8, done8;
  logic        cf16, zf16, busy16, done16;

  int   nvec = 0;
  int   nfail = 0;
  res_t mdl [2];

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .m(m), .s(s), .a(a8), .b(b8),
    .t(t8), .th(th8), .cf(cf8), .zf(zf8), .busy(busy8), .done(done8)
  );

  seq_alu #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .m(m), .s(s), .a(a16), .b(b16),
    .t(t16), .th(th16), .cf(cf16), .zf(zf16), .busy(busy16), .done(done16)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: results straight from the operation definitions using wide arithmetic
  function automatic res_t ref_op(input int w, input logic mm, input logic [3:0] ss,
                                  input logic [63:0] a, input logic [63:0] b, input res_t cur);
    res_t        r;
    logic [63:0] mask, x;
    logic        flag_op;
    mask    = (64'd1 << w) - 64'd1;
    r       = '0;
    flag_op = 1'b1;
    if (mm) begin
      case (ss)
        4'b1001: begin x = a + b;                 r.t = x & mask; r.cf = x[w]; end
        4'b1000: begin x = a + b + {63'd0, cur.cf}; r.t = x & mask; r.cf = x[w]; end
        4'b0110: begin r.t = (b - a) & mask; r.cf = (a > b); end
        4'b1011: r.t = a & b;
        4'b0101: r.t = ~b & mask;
        4'b1110: begin r.t = (b << 1) & mask; r.cf = b[w-1]; end
        4'b1101: begin r.t = b >> 1; r.cf = b[0]; end
        4'b0011: begin
          x = a * b;
          r.t = x & mask; r.th = x >> w; r.cf = (r.th != 0); r.zf = (x == 0);
          return r;
        end
        default: flag_op = 1'b0;
      endcase
      if (flag_op) r.zf = (r.t == 0);
    end else begin
      case (ss)
        4'b1010:          begin r.t = b; r.cf = cur.cf; r.zf = cur.zf; end
        4'b1100, 4'b0100: begin r.t = a; r.cf = cur.cf; r.zf = cur.zf; end
        default: ;
      endcase
    end
    return r;
  endfunction

  task automatic drive(input int w, input logic st, input logic mm, input logic [3:0] ss,
                       input logic [63:0] a, input logic [63:0] b);
    m = mm;
    s = ss;
    if (w == 8) begin a8 = a[7:0]; b8 = b[7:0]; start8 = st; end
    else        begin a16 = a[15:0]; b16 = b[15:0]; start16 = st; end
  endtask

  task automatic sample(input int w, output res_t r, output logic bsy, output logic dn);
    r = '0;
    if (w == 8) begin
      r.t = {56'd0, t8}; r.th = {56'd0, th8}; r.cf = cf8; r.zf = zf8; bsy = busy8; dn = done8;
    end else begin
      r.t = {48'd0, t16}; r.th = {48'd0, th16}; r.cf = cf16; r.zf = zf16; bsy = busy16; dn = done16;
    end
  endtask

  task automatic chk_res(input string name, input res_t r, input res_t e);
    chk({name, " t"},  r.t,  e.t);
    chk({name, " th"}, r.th, e.th);
    chk({name, " cf"}, {63'd0, r.cf}, {63'd0, e.cf});
    chk({name, " zf"}, {63'd0, r.zf}, {63'd0, e.zf});
  endtask

  // Issue one op, follow it to completion (bounded), check results and the done pulse
  task automatic run_op(input int w, input logic mm, input logic [3:0] ss,
                        input logic [63:0] a, input logic [63:0] b, input res_t e, input string name);
    res_t r, prev;
    logic bsy, dn;
    int   nb, idx;
    idx  = (w == 8) ? 0 : 1;
    prev = mdl[idx];
    drive(w, 1'b1, mm, ss, a, b);
    @(posedge clk); #1;
    drive(w, 1'b0, mm, ss, ~a, ~b);
    if (mm && ss == 4'b0011) begin
      nb = 0;
      sample(w, r, bsy, dn);
      while (bsy && nb < w + 4) begin
        nb++;
        chk({name, " hold t"}, r.t, prev.t);
        chk({name, " no early done"}, {63'd0, dn}, 64'd0);
        if (nb == 2) drive(w, 1'b1, 1'b1, 4'b1011, 64'd0, 64'd0);
        if (nb == 3) drive(w, 1'b0, 1'b1, 4'b1011, 64'd0, 64'd0);
        @(posedge clk); #1;
        sample(w, r, bsy, dn);
      end
      chk({name, " busy cycles"}, nb, w);
    end
    sample(w, r, bsy, dn);
    chk({name, " done"}, {63'd0, dn}, 64'd1);
    chk({name, " busy"}, {63'd0, bsy}, 64'd0);
    chk_res(name, r, e);
    mdl[idx] = e;
    @(posedge clk); #1;
    sample(w, r, bsy, dn);
    chk({name, " done drop"}, {63'd0, dn}, 64'd0);
    chk({name, " t held"}, r.t, e.t);
  endtask

  initial begin
    vec_t tbl [14];
    res_t e, r;
    logic bsy, dn;
    int   w, idx;
    logic mm;
    logic [3:0] ss;
    logic [63:0] ra, rb;
    logic [3:0] legal [9];

    tbl[0]  = '{1'b1, 4'b1001, 64'hFF, 64'h01, 64'h00, 64'h0,  1'b1, 1'b1};
    tbl[1]  = '{1'b1, 4'b1000, 64'h00, 64'h00, 64'h01, 64'h0,  1'b0, 1'b0};
    tbl[2]  = '{1'b1, 4'b0110, 64'h05, 64'h03, 64'hFE, 64'h0,  1'b1, 1'b0};
    tbl[3]  = '{1'b1, 4'b0110, 64'h07, 64'h07, 64'h00, 64'h0,  1'b0, 1'b1};
    tbl[4]  = '{1'b1, 4'b1011, 64'hF0, 64'h3C, 64'h30, 64'h0,  1'b0, 1'b0};
    tbl[5]  = '{1'b1, 4'b0101, 64'h00, 64'h0F, 64'hF0, 64'h0,  1'b0, 1'b0};
    tbl[6]  = '{1'b1, 4'b1110, 64'h00, 64'h80, 64'h00, 64'h0,  1'b1, 1'b1};
    tbl[7]  = '{1'b0, 4'b1100, 64'h5A, 64'h00, 64'h5A, 64'h0,  1'b1, 1'b1};
    tbl[8]  = '{1'b0, 4'b1010, 64'h00, 64'hA5, 64'hA5, 64'h0,  1'b1, 1'b1};
    tbl[9]  = '{1'b0, 4'b1111, 64'h12, 64'h34, 64'h00, 64'h0,  1'b0, 1'b0};
    tbl[10] = '{1'b1, 4'b1101, 64'h00, 64'h03, 64'h01, 64'h0,  1'b1, 1'b0};
    tbl[11] = '{1'b1, 4'b1000, 64'h10, 64'h20, 64'h31, 64'h0,  1'b0, 1'b0};
    tbl[12] = '{1'b1, 4'b0000, 64'h77, 64'h88, 64'h00, 64'h0,  1'b0, 1'b0};
    tbl[13] = '{1'b1, 4'b0011, 64'hFF, 64'hFF, 64'h01, 64'hFE, 1'b1, 1'b0};

    legal[0] = 4'b1001; legal[1] = 4'b1000; legal[2] = 4'b0110;
    legal[3] = 4'b1011; legal[4] = 4'b0101; legal[5] = 4'b1110;
    legal[6] = 4'b1101; legal[7] = 4'b0011; legal[8] = 4'b1010;

    rst = 1'b1; start8 = 1'b0; start16 = 1'b0; m = 1'b0; s = 4'b0;
    a8 = '0; b8 = '0; a16 = '0; b16 = '0;
    mdl[0] = '0; mdl[1] = '0;
    #2;
    sample(8, r, bsy, dn);
    chk_res("reset8", r, '0);
    chk("reset8 busy", {63'd0, bsy}, 64'd0);
    chk("reset8 done", {63'd0, dn}, 64'd0);
    sample(16, r, bsy, dn);
    chk_res("reset16", r, '0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    // directed 8-bit table
    for (int i = 0; i < 14; i++) begin
      e = '{tbl[i].t, tbl[i].th, tbl[i].cf, tbl[i].zf};
      run_op(8, tbl[i].m, tbl[i].s, tbl[i].a, tbl[i].b, e, $sformatf("vec%0d", i));
    end

    // 16-bit regression
    run_op(16, 1'b1, 4'b1001, 64'hFFFF, 64'h0001, '{64'h0000, 64'h0, 1'b1, 1'b1}, "w16 add");
    run_op(16, 1'b1, 4'b1000, 64'h0000, 64'h0000, '{64'h0001, 64'h0, 1'b0, 1'b0}, "w16 adc");
    run_op(16, 1'b1, 4'b0011, 64'hFFFF, 64'hFFFF, '{64'h0001, 64'hFFFE, 1'b1, 1'b0}, "w16 mul");

    // back-to-back single-cycle ops on consecutive edges
    @(posedge clk); #1;
    drive(8, 1'b1, 1'b1, 4'b1001, 64'h01, 64'h02);
    @(posedge clk); #1;
    sample(8, r, bsy, dn);
    chk("b2b first done", {63'd0, dn}, 64'd1);
    chk("b2b first t", r.t, 64'h03);
    drive(8, 1'b1, 1'b1, 4'b1011, 64'h0F, 64'h3C);
    @(posedge clk); #1;
    drive(8, 1'b0, 1'b1, 4'b1011, 64'h0F, 64'h3C);
    sample(8, r, bsy, dn);
    chk("b2b second done", {63'd0, dn}, 64'd1);
    chk_res("b2b second", r, '{64'h0C, 64'h0, 1'b0, 1'b0});
    mdl[0] = '{64'h0C, 64'h0, 1'b0, 1'b0};
    @(posedge clk); #1;
    sample(8, r, bsy, dn);
    chk("b2b done drop", {63'd0, dn}, 64'd0);

    // reset in the middle of a multiply, with start held through reset
    drive(8, 1'b1, 1'b1, 4'b0011, 64'hFF, 64'hFF);
    @(posedge clk); #1;
    drive(8, 1'b0, 1'b1, 4'b0011, 64'hFF, 64'hFF);
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    sample(8, r, bsy, dn);
    chk_res("abort", r, '0);
    chk("abort busy", {63'd0, bsy}, 64'd0);
    chk("abort done", {63'd0, dn}, 64'd0);
    drive(8, 1'b1, 1'b1, 4'b1011, 64'hF0, 64'h3C);
    repeat (2) @(posedge clk);
    #1;
    sample(8, r, bsy, dn);
    chk("start in rst ignored done", {63'd0, dn}, 64'd0);
    chk("start in rst ignored t", r.t, 64'h0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    drive(8, 1'b0, 1'b1, 4'b1011, 64'hF0, 64'h3C);
    sample(8, r, bsy, dn);
    chk("post rst done", {63'd0, dn}, 64'd1);
    chk_res("post rst and", r, '{64'h30, 64'h0, 1'b0, 1'b0});
    mdl[0] = '{64'h30, 64'h0, 1'b0, 1'b0};
    mdl[1] = '0;
    @(posedge clk); #1;

    // random ops against the reference model
    for (int i = 0; i < 250; i++) begin
      w   = ($urandom_range(0, 1) == 0) ? 8 : 16;
      idx = (w == 8) ? 0 : 1;
      if ($urandom_range(0, 9) < 8) begin
        ss = legal[$urandom_range(0, 8)];
        mm = (ss != 4'b1010);
        if ($urandom_range(0, 5) == 0) begin mm = 1'b0; ss = 4'b1100; end
      end else begin
        mm = 1'($urandom_range(0, 1));
        ss = 4'($urandom_range(0, 15));
      end
      ra = {32'd0, $urandom} & ((64'd1 << w) - 64'd1);
      rb = {32'd0, $urandom} & ((64'd1 << w) - 64'd1);
      if ($urandom_range(0, 7) == 0) ra = 64'd0;
      e = ref_op(w, mm, ss, ra, rb, mdl[idx]);
      run_op(w, mm, ss, ra, rb, e, $sformatf("rnd%0d w%0d m%0d s%b", i, w, mm, ss));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 8, operand/result width (legal range 4..32).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  operation request; sampled only in IDLE.
REQ-005 m  input  1  mode: 1 = arithmetic/logic, 0 = pass-through.
REQ-006 s  input  4  operation select.
REQ-007 a, b  input  WIDTH each  operands.
REQ-008 t  output  WIDTH  registered result (low half for MUL).
REQ-009 th  output  WIDTH  registered high half of MUL product; 0 for all other ops.
REQ-010 cf, zf  output  1 each  registered carry/borrow and zero flags.
REQ-011 busy  output  1  high while a multi-cycle op is in progress.
REQ-012 done  output  1  one-cycle pulse when t/th/flags have been updated.

Function
REQ-013 The FSM SHALL have states IDLE and MUL; busy = (state == MUL).
REQ-014 On a rising edge in IDLE with start=1, m, s, a and b SHALL be latched; start in MUL SHALL be ignored and not queued.
REQ-015 Single-cycle ops SHALL update t/th/flags on the accepting edge, assert done for the following cycle, and remain in IDLE (back-to-back starts allowed every cycle).
REQ-016 m=1, s=1001 ADD: {cf,t} = a+b (WIDTH+1 bits).
REQ-017 m=1, s=1000 ADC: {cf,t} = a+b+cf, using the registered cf at the accepting edge.
REQ-018 m=1, s=0110 SUB: {cf,t} = b-a; cf=1 when a>b (borrow).
REQ-019 m=1, s=1011 AND: t = a&b, cf=0.
REQ-020 m=1, s=0101 NOT: t = ~b, cf=0.
REQ-021 m=1, s=1110 SHL: t = b<<1, cf = b[WIDTH-1]; s=1101 SHR: t = b>>1 (logical), cf = b[0].
REQ-022 m=1, s=0011 MUL: unsigned, multi-cycle shift-add; enter MUL on the accepting edge, iterate exactly WIDTH edges, then write {th,t} = a*b, cf = (th != 0), return to IDLE, assert done the following cycle.
REQ-023 MUL latency: done SHALL be high in the cycle after the (WIDTH+1)-th rising edge counted from and including the accepting edge; t/th/flags SHALL hold previous values until then.
REQ-024 For every m=1 op, zf SHALL be 1 iff the new t == 0 (MUL: iff the full 2*WIDTH product == 0).
REQ-025 m=0, s=1010: t = b; s=1100 or s=0100: t = a; cf and zf unchanged.
REQ-026 Any other {m,s} combination SHALL give t=0, th=0, cf=0, zf=0, and done SHALL still pulse.
REQ-027 th SHALL be written to 0 by every completed non-MUL op.
REQ-028 Operand inputs changing after the accepting edge SHALL NOT affect an in-progress MUL.
REQ-029 Arithmetic SHALL wrap modulo 2^WIDTH in t; the overflow bit goes only to cf.

Reset
REQ-030 rst=1 SHALL immediately force state=IDLE, t=0, th=0, cf=0, zf=0, busy=0, done=0, and clear the iteration counter and latched operands.
REQ-031 rst asserted during MUL SHALL abort the op with no done pulse and no output update; after deassertion the first start is accepted normally.
REQ-032 start held high during rst SHALL be ignored; it is sampled on the first edge after rst deasserts.

Verification
REQ-033 WIDTH=8, ADD a=0xFF b=0x01 -> next cycle t=0x00, cf=1, zf=1, done=1 for one cycle; then ADC a=0x00 b=0x00 -> t=0x01, cf=0, zf=0.
REQ-034 WIDTH=8, SUB a=0x05 b=0x03 -> t=0xFE, cf=1, zf=0; SUB a=0x07 b=0x07 -> t=0x00, cf=0, zf=1.
REQ-035 WIDTH=8, MUL a=0xFF b=0xFF -> busy=1 for 8 cycles, then th=0xFE, t=0x01, cf=1, zf=0, done one cycle; start pulses during busy produce no effect.
REQ-036 WIDTH=8, MUL in progress, rst pulse at iteration 4 -> all outputs 0, no done; a following AND a=0xF0 b=0x3C -> t=0x30, cf=0, zf=0.
REQ-037 WIDTH=8, set cf=1 via SHL b=0x80 (t=0x00, zf=1), then m=0 s=1100 a=0x5A -> t=0x5A, cf=1, zf=1 retained; then m=0 s=1111 -> t=0, cf=0, zf=0, done=1.
REQ-038 WIDTH=16 regression of REQ-033 and REQ-035 with a=0xFFFF, b=0xFFFF MUL -> 16 busy cycles, th=0xFFFE, t=0x0001.
